// File: rtl/freq_pkg.sv
// Shared definitions for the frequency display: conversion FSM encoding,
// seven-segment cathode table and the largest value the 8-digit display can show.
package freq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } cvt_state_t;

  localparam logic [31:0] DISP_MAX  = 32'd99_999_999;
  localparam logic [31:0] BCD_ALL9  = 32'h9999_9999;
  localparam logic [7:0]  SEG_BLANK = 8'hFF;

  // Active-low a..g plus dp (bit 7, always off); entry 9 is listed first.
  localparam logic [9:0][7:0] SEG_LUT = {
    8'h90, 8'h80, 8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };

  function automatic logic [7:0] seg_decode(input logic [3:0] d);
    if (d > 4'd9) return SEG_BLANK;
    return SEG_LUT[d];
  endfunction

endpackage

// File: rtl/bin2bcd.sv
// 32-bit binary to BCD via double-dabble; one iteration per clock, 32 clocks after start.
// start is honoured at any time; done is high during the final iteration cycle.
module bin2bcd (
  input  logic        clk_100kHz,
  input  logic        rst_,
  input  logic        start,
  input  logic [31:0] bin,
  output logic        busy,
  output logic        done,
  output logic [31:0] bcd
);

  logic [31:0] sh;
  logic [39:0] acc;
  logic [39:0] adj;
  logic [4:0]  cnt;

  // Add-3 correction on every digit before the shift, so no digit can exceed 9 after doubling.
  always_comb begin
    adj = acc;
    for (int i = 0; i < 10; i++) begin
      if (acc[4*i +: 4] >= 4'd5) adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk_100kHz or posedge rst_) begin
    if (rst_) begin
      sh   <= '0;
      acc  <= '0;
      cnt  <= '0;
      busy <= 1'b0;
    end else if (start) begin
      sh   <= bin;
      acc  <= '0;
      cnt  <= '0;
      busy <= 1'b1;
    end else if (busy) begin
      {acc, sh} <= {adj, sh} << 1;
      cnt       <= cnt + 5'd1;
      if (cnt == 5'd31) busy <= 1'b0;
    end
  end

  assign done = busy && (cnt == 5'd31);
  assign bcd  = acc[31:0];

endmodule

// File: rtl/freq_display.sv
// Latches freq_real as 8-digit BCD (33-clock conversion per change) and scans it onto a
// multiplexed 7-segment display; new values arriving mid-conversion wait for the next IDLE.
module freq_display #(
  parameter int SCAN_DIV = 100,
  parameter int BLANK_LZ = 1
) (
  input  logic        clk_100kHz,
  input  logic        rst_,
  input  logic [31:0] freq_real,
  output logic [31:0] bcd,
  output logic        overflow,
  output logic        busy,
  output logic [7:0]  an,
  output logic [7:0]  seg
);
  import freq_pkg::*;

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

  cvt_state_t  state, state_nxt;
  logic [31:0] last_value;
  logic        overflow_next;
  logic        cvt_start, cvt_busy, cvt_done;
  logic [31:0] cvt_bcd;

  assign cvt_start = (state == ST_IDLE) && (freq_real != last_value);

  bin2bcd u_bin2bcd (
    .clk_100kHz (clk_100kHz),
    .rst_       (rst_),
    .start      (cvt_start),
    .bin        (freq_real),
    .busy       (cvt_busy),
    .done       (cvt_done),
    .bcd        (cvt_bcd)
  );

  always_ff @(posedge clk_100kHz or posedge rst_) begin
    if (rst_) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (cvt_start) state_nxt = ST_SHIFT;
      ST_SHIFT: if (cvt_done || !cvt_busy) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    if (state != ST_IDLE) busy = 1'b1;
  end

  always_ff @(posedge clk_100kHz or posedge rst_) begin
    if (rst_) begin
      last_value    <= '0;
      overflow_next <= 1'b0;
      bcd           <= '0;
      overflow      <= 1'b0;
    end else begin
      if (cvt_start) begin
        last_value    <= freq_real;
        overflow_next <= (freq_real > DISP_MAX);
      end
      if (state == ST_DONE) begin
        bcd      <= overflow_next ? BCD_ALL9 : cvt_bcd;
        overflow <= overflow_next;
      end
    end
  end

  logic [DIV_W-1:0] div_cnt;
  logic [2:0]       index;
  logic [3:0]       digit;
  logic             blank;

  always_ff @(posedge clk_100kHz or posedge rst_) begin
    if (rst_) begin
      div_cnt <= '0;
      index   <= '0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt <= '0;
      index   <= index + 3'd1;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  // A digit is a leading zero when it and every digit above it are zero.
  always_comb begin
    digit = bcd[{index, 2'b00} +: 4];
    blank = 1'b0;
    if (BLANK_LZ != 0 && index != 3'd0) blank = ((bcd >> {index, 2'b00}) == 32'd0);
  end

  always_ff @(posedge clk_100kHz or posedge rst_) begin
    if (rst_) begin
      an  <= 8'hFF;
      seg <= SEG_BLANK;
    end else begin
      an  <= ~(8'h01 << index);
      seg <= blank ? SEG_BLANK : seg_decode(digit);
    end
  end

endmodule

// File: tb/tb_freq_display.sv
// Directed and randomized bench for freq_display against a decimal-arithmetic reference model;
// two instances share inputs to cover both leading-zero blanking settings.
module tb_freq_display;

  logic        clk_100kHz = 1'b0;
  logic        rst_;
  logic [31:0] freq_real;
  logic [31:0] bcd, nb_bcd;
  logic        overflow, nb_overflow, busy, nb_busy;
  logic [7:0]  an, nb_an, seg, nb_seg;

  int checks = 0;
  int errors = 0;

  logic [7:0] segtab [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                              8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

  always #5 clk_100kHz = ~clk_100kHz;

  freq_display #(.SCAN_DIV(4), .BLANK_LZ(1)) dut (
    .clk_100kHz (clk_100kHz), .rst_ (rst_), .freq_real (freq_real),
    .bcd (bcd), .overflow (overflow), .busy (busy), .an (an), .seg (seg)
  );

  freq_display #(.SCAN_DIV(4), .BLANK_LZ(0)) dut_nb (
    .clk_100kHz (clk_100kHz), .rst_ (rst_), .freq_real (freq_real),
    .bcd (nb_bcd), .overflow (nb_overflow), .busy (nb_busy), .an (nb_an), .seg (nb_seg)
  );

  task automatic tick();
    @(posedge clk_100kHz);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_bcd(input logic [31:0] v);
    logic [31:0] r = '0;
    longint unsigned x = v;
    if (v > 32'd99_999_999) return 32'h9999_9999;
    for (int k = 0; k < 8; k++) begin
      r[4*k +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic [7:0] model_seg(input logic [31:0] v, input int k, input bit blank_lz);
    longint unsigned p = 1;
    for (int i = 0; i < k; i++) p = p * 10;
    if (blank_lz && k > 0 && longint'(v) < p) return 8'hFF;
    return segtab[int'((longint'(v) / p) % 10)];
  endfunction

  // Ticks until busy drops, counting busy-high samples (pre already counted by the caller).
  task automatic finish_conv(input int pre, input logic [31:0] v, input string tag);
    int          n     = pre;
    logic [31:0] prev  = bcd;
    bit          held  = 1'b1;
    bit          ended = 1'b0;
    for (int i = 0; i < 100 && !ended; i++) begin
      tick();
      if (busy) begin
        n++;
        if (bcd !== prev) held = 1'b0;
      end else begin
        ended = 1'b1;
      end
    end
    check({tag, "_busy_cycles"}, 32'(n), 32'd33);
    check({tag, "_bcd_hold"}, {31'b0, held}, 32'd1);
    check({tag, "_bcd"}, bcd, model_bcd(v));
    check({tag, "_bcd_noblank"}, nb_bcd, model_bcd(v));
    check({tag, "_ovf"}, {31'b0, overflow}, {31'b0, (v > 32'd99_999_999)});
  endtask

  task automatic scan_check(input logic [31:0] v, input string tag);
    int guard = 0;
    while (an == 8'hFE && guard < 60) begin tick(); guard++; end
    while (an != 8'hFE && guard < 120) begin tick(); guard++; end
    check({tag, "_sync"}, {31'b0, (guard < 120)}, 32'd1);
    for (int k = 0; k <= 8; k++) begin
      int         d     = k % 8;
      int         dwell = 0;
      logic [7:0] e     = 8'h01 << d;
      e = ~e;
      check($sformatf("%s_an%0d", tag, k), {24'b0, an}, {24'b0, e});
      check($sformatf("%s_seg%0d", tag, k), {24'b0, seg}, {24'b0, model_seg(v, d, 1'b1)});
      check($sformatf("%s_segnb%0d", tag, k), {24'b0, nb_seg}, {24'b0, model_seg(v, d, 1'b0)});
      if (k == 8) break;
      while (an == e && dwell < 20) begin tick(); dwell++; end
      check($sformatf("%s_dwell%0d", tag, k), 32'(dwell), 32'd4);
    end
  endtask

  initial begin
    logic [31:0] v;
    logic [31:0] prev_v;
    int          pre;

    rst_      = 1'b1;
    freq_real = 32'd1234;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("rst_an", {24'b0, an}, 32'h0000_00FF);
      check("rst_seg", {24'b0, seg}, 32'h0000_00FF);
      check("rst_bcd", bcd, 32'd0);
      check("rst_busy", {31'b0, busy}, 32'd0);
    end

    freq_real = 32'd0;
    rst_      = 1'b0;
    tick();
    tick();
    check("idle_zero_busy", {31'b0, busy}, 32'd0);

    freq_real = 32'd1234;
    finish_conv(0, 32'd1234, "c1234");
    scan_check(32'd1234, "scan1234");

    freq_real = 32'd99_999_999;
    finish_conv(0, 32'd99_999_999, "dispmax");
    freq_real = 32'd100_000_000;
    finish_conv(0, 32'd100_000_000, "dispmax_p1");

    prev_v = freq_real;
    for (int i = 0; i < 4; i++) begin
      v = 32'($urandom_range(0, 99_999_999));
      if (v == prev_v) v = v ^ 32'd1;
      freq_real = v;
      finish_conv(0, v, $sformatf("rnd%0d", i));
      prev_v = v;
    end
    scan_check(prev_v, "scan_rnd");

    for (int i = 0; i < 2; i++) begin
      v = $urandom | 32'h8000_0000;
      if (v == prev_v) v = v ^ 32'd1;
      freq_real = v;
      finish_conv(0, v, $sformatf("rnd_ovf%0d", i));
      prev_v = v;
    end

    freq_real = 32'd10;
    pre = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (busy) pre++;
    end
    freq_real = 32'd50;
    finish_conv(pre, 32'd10, "mid_change_first");
    finish_conv(0, 32'd50, "mid_change_second");

    freq_real = 32'd77;
    for (int i = 0; i < 10; i++) tick();
    check("pre_abort_busy", {31'b0, busy}, 32'd1);
    rst_ = 1'b1;
    #1;
    check("abort_bcd_async", bcd, 32'd0);
    check("abort_busy_async", {31'b0, busy}, 32'd0);
    check("abort_an_async", {24'b0, an}, 32'h0000_00FF);
    tick();
    tick();
    check("abort_bcd_held", bcd, 32'd0);
    check("abort_seg_held", {24'b0, seg}, 32'h0000_00FF);
    rst_ = 1'b0;
    finish_conv(0, 32'd77, "post_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
